// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side is the datapath: it reports hazard status and receives stage controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             MemRead_EX;
  logic [4:0]       Rt_EX;
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             UsesRt_ID;
  logic             BranchTaken_EX;
  logic [1:0]       Jump_EX;
  logic             DMemReq_MEM;
  logic             DMemReady;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             Flush_IFID;
  logic             Flush_IDEX;
  logic             Hold_IDEX;
  logic             Hold_EXMEM;
  logic             MemAbort;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX, Jump_EX,
           DMemReq_MEM, DMemReady,
    input  PCWrite, IF_ID_Write, Flush_IFID, Flush_IDEX, Hold_IDEX, Hold_EXMEM,
           MemAbort, MemTimeout, StallCycles
  );

  modport slave (
    input  MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID, BranchTaken_EX, Jump_EX,
           DMemReq_MEM, DMemReady,
    output PCWrite, IF_ID_Write, Flush_IFID, Flush_IDEX, Hold_IDEX, Hold_EXMEM,
           MemAbort, MemTimeout, StallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirects,
// data-memory waits with timeout abort, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT      = 16,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input logic                   Clk,
  input logic                   Reset_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam int RW = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [RW-1:0] RED_LOAD  = RW'(REDIRECT_BUBBLES - 1);

  logic [1:0]       state, state_nxt;
  logic [WW-1:0]    wait_cnt;
  logic [RW-1:0]    red_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;
  logic             memwait, redirect, loaduse, abort;
  logic             pc_we, ifid_we, fl_ifid, fl_idex, hd_idex, hd_exmem, mem_abort;

  assign memwait  = hz.DMemReq_MEM & ~hz.DMemReady;
  assign redirect = hz.BranchTaken_EX | (hz.Jump_EX != 2'b00);
  assign loaduse  = hz.MemRead_EX & (hz.Rt_EX != 5'd0) &
                    ((hz.Rt_EX == hz.Rs_ID) | (hz.UsesRt_ID & (hz.Rt_EX == hz.Rt_ID)));
  // wait_cnt is zero on the first wait cycle, so the abort lands on wait cycle MEM_TIMEOUT
  assign abort    = memwait & (wait_cnt == WAIT_LAST);

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    hd_idex   = 1'b0;
    hd_exmem  = 1'b0;
    mem_abort = 1'b0;
    state_nxt = state;
    if (!Reset_n) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      fl_ifid   = 1'b1;
      fl_idex   = 1'b1;
      state_nxt = RUN;
    end else if (abort) begin
      mem_abort = 1'b1;
      if (state == MEM_WAIT) state_nxt = RUN;
    end else if (memwait) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      hd_idex  = 1'b1;
      hd_exmem = 1'b1;
      if (state == RUN) state_nxt = MEM_WAIT;
    end else begin
      case (state)
        MEM_WAIT: state_nxt = RUN;
        REDIRECT: begin
          fl_ifid = 1'b1;
          if (red_cnt == RW'(1)) state_nxt = RUN;
        end
        default: begin
          if (redirect) begin
            fl_ifid = 1'b1;
            fl_idex = 1'b1;
            if (REDIRECT_BUBBLES > 1) state_nxt = REDIRECT;
          end else if (loaduse) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            fl_idex = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      red_cnt   <= '0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (memwait && !abort) wait_cnt <= wait_cnt + 1'b1;
      else                   wait_cnt <= '0;
      if (abort) timeout_q <= 1'b1;
      // bubble count pauses while memory freezes the pipe
      if (state == RUN && !memwait && redirect)
        red_cnt <= RED_LOAD;
      else if (state == REDIRECT && !memwait && red_cnt != '0)
        red_cnt <= red_cnt - 1'b1;
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.PCWrite     = pc_we;
  assign hz.IF_ID_Write = ifid_we;
  assign hz.Flush_IFID  = fl_ifid;
  assign hz.Flush_IDEX  = fl_idex;
  assign hz.Hold_IDEX   = hd_idex;
  assign hz.Hold_EXMEM  = hd_exmem;
  assign hz.MemAbort    = mem_abort;
  assign hz.MemTimeout  = timeout_q;
  assign hz.StallCycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hz1 ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .REDIRECT_BUBBLES(2), .CNT_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .hz(hz0.slave));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .REDIRECT_BUBBLES(1), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset_n(Reset_n), .hz(hz1.slave));

  typedef struct packed {
    logic       rst, mr;
    logic [4:0] rte, rsi, rti;
    logic       u, br;
    logic [1:0] j;
    logic       rq, rd;
  } in_t;

  // flags = {PCWrite, IF_ID_Write, Flush_IFID, Flush_IDEX, Hold_IDEX, Hold_EXMEM, MemAbort, MemTimeout}
  typedef struct packed {
    logic [7:0]  f;
    logic [15:0] stall;
  } exp_t;

  typedef struct {
    string      nm;
    exp_t       e;
    logic       c1;
    logic [3:0] s1;
  } ent_t;

  localparam logic [7:0] DEF = 8'b1100_0000, LU = 8'b0001_0000, RD = 8'b1111_0000,
                         BUB = 8'b1110_0000, FRZ = 8'b0000_1100, RST = 8'b0011_0000,
                         ABT = 8'b1100_0010, DEFT = 8'b1100_0001, FRZT = 8'b0000_1101;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic in_t I(logic mr, logic [4:0] rte, logic [4:0] rsi, logic [4:0] rti,
                            logic u, logic br, logic [1:0] j, logic rq, logic rd);
    in_t v;
    v = '{rst: 1'b1, mr: mr, rte: rte, rsi: rsi, rti: rti, u: u, br: br, j: j, rq: rq, rd: rd};
    return v;
  endfunction

  function automatic in_t Ir(in_t v);
    in_t r;
    r = v;
    r.rst = 1'b0;
    return r;
  endfunction

  function automatic exp_t E(logic [7:0] f, int s);
    exp_t e;
    e.f = f;
    e.stall = 16'(s);
    return e;
  endfunction

  task automatic drive(input in_t v);
    Reset_n = v.rst;
    hz0.MemRead_EX = v.mr;  hz1.MemRead_EX = v.mr;
    hz0.Rt_EX = v.rte;      hz1.Rt_EX = v.rte;
    hz0.Rs_ID = v.rsi;      hz1.Rs_ID = v.rsi;
    hz0.Rt_ID = v.rti;      hz1.Rt_ID = v.rti;
    hz0.UsesRt_ID = v.u;    hz1.UsesRt_ID = v.u;
    hz0.BranchTaken_EX = v.br; hz1.BranchTaken_EX = v.br;
    hz0.Jump_EX = v.j;      hz1.Jump_EX = v.j;
    hz0.DMemReq_MEM = v.rq; hz1.DMemReq_MEM = v.rq;
    hz0.DMemReady = v.rd;   hz1.DMemReady = v.rd;
  endtask

  task automatic vec(input string nm, input in_t v, input exp_t e,
                     input logic c1, input logic [3:0] s1);
    ent_t x;
    @(posedge Clk);
    #1;
    drive(v);
    x.nm = nm; x.e = e; x.c1 = c1; x.s1 = s1;
    sb.push_back(x);
  endtask

  ent_t x_m;
  exp_t act;
  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      x_m = sb.pop_front();
      act.f = {hz0.PCWrite, hz0.IF_ID_Write, hz0.Flush_IFID, hz0.Flush_IDEX,
               hz0.Hold_IDEX, hz0.Hold_EXMEM, hz0.MemAbort, hz0.MemTimeout};
      act.stall = hz0.StallCycles;
      n_vec++;
      if (act !== x_m.e || (x_m.c1 && hz1.StallCycles !== x_m.s1)) begin
        n_err++;
        $display("FAIL %s: got flags=%b stall=%0d stall4=%0d, required flags=%b stall=%0d stall4=%0d",
                 x_m.nm, act.f, act.stall, hz1.StallCycles, x_m.e.f, x_m.e.stall, x_m.s1);
      end
    end
  end

  initial begin
    in_t nop, wt, lu;
    nop = I(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    wt  = I(0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    lu  = I(1, 8, 8, 0, 0, 0, 2'd0, 0, 0);
    drive(Ir(nop));

    vec("reset",        Ir(nop), E(RST, 0), 0, 0);
    vec("idle",         nop, E(DEF, 0), 0, 0);
    vec("lu_rs",        lu,  E(LU, 0), 0, 0);
    vec("lu_release",   nop, E(DEF, 1), 0, 0);
    vec("lu_rt_zero",   I(1, 0, 0, 0, 1, 0, 2'd0, 0, 0), E(DEF, 1), 0, 0);
    vec("lu_rt_unused", I(1, 9, 3, 9, 0, 0, 2'd0, 0, 0), E(DEF, 1), 0, 0);
    vec("lu_rt_used",   I(1, 9, 3, 9, 1, 0, 2'd0, 0, 0), E(LU, 1), 0, 0);
    vec("no_load",      I(0, 9, 3, 9, 1, 0, 2'd0, 0, 0), E(DEF, 2), 0, 0);
    vec("br_over_lu",   I(1, 8, 8, 0, 0, 1, 2'd0, 0, 0), E(RD, 2), 0, 0);
    vec("br_bubble",    nop, E(BUB, 2), 0, 0);
    vec("br_done",      nop, E(DEF, 2), 0, 0);
    vec("jump",         I(0, 0, 0, 0, 0, 0, 2'd2, 0, 0), E(RD, 2), 0, 0);
    vec("jump_bubble",  nop, E(BUB, 2), 0, 0);
    for (int k = 0; k < 3; k++)
      vec("mem_hold_br", I(0, 0, 0, 0, 0, 1, 2'd0, 1, 0), E(FRZ, 2 + k), 0, 0);
    vec("mem_ready",      I(0, 0, 0, 0, 0, 1, 2'd0, 1, 1), E(DEF, 5), 0, 0);
    vec("held_br",        I(0, 0, 0, 0, 0, 1, 2'd0, 0, 0), E(RD, 5), 0, 0);
    vec("held_br_bubble", nop, E(BUB, 5), 0, 0);
    vec("br2",            I(0, 0, 0, 0, 0, 1, 2'd0, 0, 0), E(RD, 5), 0, 0);
    vec("redir_wait",     wt,  E(FRZ, 5), 0, 0);
    vec("redir_resume",   nop, E(BUB, 6), 0, 0);
    vec("redir_done",     nop, E(DEF, 6), 0, 0);
    for (int k = 1; k <= 15; k++)
      vec("to_wait", wt, E(FRZ, 5 + k), 0, 0);
    vec("to_abort",  wt,  E(ABT, 21), 0, 0);
    vec("to_sticky", nop, E(DEFT, 21), 0, 0);
    for (int k = 1; k <= 4; k++)
      vec("rst_wait", wt, E(FRZT, 20 + k), 0, 0);
    vec("rst_async",     Ir(wt), E(RST, 0), 0, 0);
    vec("rst_release",   nop, E(DEF, 0), 0, 0);
    vec("post_rst_wait", wt,  E(FRZ, 0), 0, 0);
    vec("post_rst_idle", nop, E(DEF, 1), 0, 0);
    vec("sat_reset",     Ir(nop), E(RST, 0), 1, 4'd0);
    for (int k = 1; k <= 20; k++)
      vec("sat_lu", lu, E(LU, k - 1), 1, 4'((k - 1 > 15) ? 15 : k - 1));
    vec("sat_hold", nop, E(DEF, 20), 1, 4'd15);

    @(posedge Clk);
    repeat (3) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
